ocd_frame_uart_tx: RTL and testbench

- Hardware initiator for the on-chip debug (OCD) serial link: builds one fixed-format debug command frame (sync, cmd, address, data, checksum) and serializes it as 8N1 UART onto a line that drives the OCD RXD.
- Used for on-board self-load and test stimulus: program-RAM write/read commands and CPU start/reset commands without an external host.
- Sits beside the debug coprocessor wrapper in the clk domain; its TXD connects directly to the OCD RXD input.

---
 rtl/ocd_frame_uart_tx.sv | 157 +++++++++++++++
 tb/tb_ocd_frame_uart_tx.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/ocd_frame_uart_tx.sv
// OCD debug-link initiator: builds a 12-byte command frame (sync, cmd, addr,
// data, XOR checksum) and shifts it out as back-to-back 8N1 UART characters.
module ocd_frame_uart_tx #(
  parameter int          BAUD_PERIOD = 868,
  parameter logic [7:0]  SYNC0       = 8'h5A,
  parameter logic [7:0]  SYNC1       = 8'hA5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  cmd,
  input  logic [31:0] addr,
  input  logic [31:0] data,
  output logic        busy,
  output logic        done,
  output logic        TXD
);

  typedef enum logic [1:0] {IDLE, START_BIT, DATA_BITS, STOP_BIT} state_t;

  localparam logic [15:0] BAUD_LAST = 16'(BAUD_PERIOD - 1);
  localparam logic [3:0]  LAST_BYTE = 4'd11;

  state_t      r_state, w_state_next;
  logic [15:0] r_baud_cnt, w_baud_cnt_next;
  logic [2:0]  r_bit_idx, w_bit_idx_next;
  logic [3:0]  r_byte_idx, w_byte_idx_next;
  logic [7:0]  r_cmd, r_chk;
  logic [31:0] r_addr, r_data;
  logic        r_txd, r_busy, r_done;
  logic        w_accept, w_baud_last, w_txd_next, w_done_next;
  logic [7:0]  w_tx_byte;

  assign w_accept    = start && !r_busy;
  assign w_baud_last = (r_baud_cnt == BAUD_LAST);

  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_baud_cnt <= '0;
      r_bit_idx  <= '0;
      r_byte_idx <= '0;
    end else begin
      r_state    <= w_state_next;
      r_baud_cnt <= w_baud_cnt_next;
      r_bit_idx  <= w_bit_idx_next;
      r_byte_idx <= w_byte_idx_next;
    end
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_state_next    = r_state;
    w_baud_cnt_next = r_baud_cnt;
    w_bit_idx_next  = r_bit_idx;
    w_byte_idx_next = r_byte_idx;
    case (r_state)
      IDLE: begin
        w_baud_cnt_next = '0;
        w_bit_idx_next  = '0;
        w_byte_idx_next = '0;
        if (w_accept) w_state_next = START_BIT;
      end
      START_BIT: begin
        if (w_baud_last) begin
          w_baud_cnt_next = '0;
          w_state_next    = DATA_BITS;
        end else begin
          w_baud_cnt_next = r_baud_cnt + 16'd1;
        end
      end
      DATA_BITS: begin
        if (w_baud_last) begin
          w_baud_cnt_next = '0;
          if (r_bit_idx == 3'd7) begin
            w_bit_idx_next = '0;
            w_state_next   = STOP_BIT;
          end else begin
            w_bit_idx_next = r_bit_idx + 3'd1;
          end
        end else begin
          w_baud_cnt_next = r_baud_cnt + 16'd1;
        end
      end
      STOP_BIT: begin
        if (w_baud_last) begin
          w_baud_cnt_next = '0;
          if (r_byte_idx == LAST_BYTE) begin
            w_byte_idx_next = '0;
            w_state_next    = IDLE;
          end else begin
            w_byte_idx_next = r_byte_idx + 4'd1;
            w_state_next    = START_BIT;
          end
        end else begin
          w_baud_cnt_next = r_baud_cnt + 16'd1;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // TXD is registered, so it is derived from the next state and next indices.
  always_comb begin
    w_tx_byte = 8'hFF;
    case (w_byte_idx_next)
      4'd0:    w_tx_byte = SYNC0;
      4'd1:    w_tx_byte = SYNC1;
      4'd2:    w_tx_byte = r_cmd;
      4'd3:    w_tx_byte = r_addr[31:24];
      4'd4:    w_tx_byte = r_addr[23:16];
      4'd5:    w_tx_byte = r_addr[15:8];
      4'd6:    w_tx_byte = r_addr[7:0];
      4'd7:    w_tx_byte = r_data[31:24];
      4'd8:    w_tx_byte = r_data[23:16];
      4'd9:    w_tx_byte = r_data[15:8];
      4'd10:   w_tx_byte = r_data[7:0];
      4'd11:   w_tx_byte = r_chk;
      default: w_tx_byte = 8'hFF;
    endcase
    case (w_state_next)
      START_BIT: w_txd_next = 1'b0;
      DATA_BITS: w_txd_next = w_tx_byte[w_bit_idx_next];
      default:   w_txd_next = 1'b1;
    endcase
    w_done_next = (r_state == STOP_BIT) && w_baud_last && (r_byte_idx == LAST_BYTE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_txd  <= 1'b1;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_cmd  <= '0;
      r_addr <= '0;
      r_data <= '0;
      r_chk  <= '0;
    end else begin
      r_txd  <= w_txd_next;
      r_busy <= (w_state_next != IDLE);
      r_done <= w_done_next;
      if (w_accept) begin
        r_cmd  <= cmd;
        r_addr <= addr;
        r_data <= data;
        r_chk  <= cmd ^ addr[31:24] ^ addr[23:16] ^ addr[15:8] ^ addr[7:0]
                      ^ data[31:24] ^ data[23:16] ^ data[15:8] ^ data[7:0];
      end
    end
  end

  assign TXD  = r_txd;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_ocd_frame_uart_tx.sv
// Bench for ocd_frame_uart_tx: cycle-exact frame capture at a 4-cycle bit
// period, plus a mid-bit-sampling receiver on a slower second instance.
module tb_ocd_frame_uart_tx;

  localparam int BP      = 4;
  localparam int BP_SLOW = 52;
  localparam int NS      = 120 * BP;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, busy, done, txd;
  logic [7:0]  cmd;
  logic [31:0] addr, data;
  logic        start_s, busy_s, done_s, txd_s;
  logic [7:0]  cmd_s;
  logic [31:0] addr_s, data_s;

  int n_pass  = 0;
  int n_total = 0;

  logic s_txd  [0:NS];
  logic s_busy [0:NS];
  logic s_done [0:NS];

  typedef struct {
    string       name;
    logic [7:0]  cmd;
    logic [31:0] addr;
    logic [31:0] data;
    logic [95:0] exp;
  } vec_t;

  vec_t vecs [3];

  always #5 clk = ~clk;

  ocd_frame_uart_tx #(.BAUD_PERIOD(BP)) u_dut (
    .clk(clk), .reset(reset), .start(start), .cmd(cmd), .addr(addr), .data(data),
    .busy(busy), .done(done), .TXD(txd)
  );

  ocd_frame_uart_tx #(.BAUD_PERIOD(BP_SLOW)) u_dut_slow (
    .clk(clk), .reset(reset), .start(start_s), .cmd(cmd_s), .addr(addr_s), .data(data_s),
    .busy(busy_s), .done(done_s), .TXD(txd_s)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else n_pass++;
  endtask

  // Pulses start for one cycle; returns on the first negedge after acceptance.
  task automatic send(input string tag, input logic [7:0] c, input logic [31:0] a, input logic [31:0] d);
    check({tag, " idle txd"}, 32'(txd), 32'd1);
    start = 1'b1; cmd = c; addr = a; data = d;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Records NS+1 negedge samples; optionally pulses start (with new fields) at sample inj.
  task automatic capture(input int inj, input logic [7:0] c, input logic [31:0] a, input logic [31:0] d);
    for (int i = 0; i <= NS; i++) begin
      s_txd[i] = txd; s_busy[i] = busy; s_done[i] = done;
      if (i == inj) begin
        start = 1'b1; cmd = c; addr = a; data = d;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  task automatic check_frame(input string tag, input logic [95:0] exp);
    int         ferr, nbusy, ndone;
    logic [7:0] b;
    ferr = 0; nbusy = 0; ndone = 0;
    for (int k = 0; k < 120; k++)
      for (int s = 1; s < BP; s++)
        if (s_txd[BP*k+s] !== s_txd[BP*k]) ferr++;
    for (int j = 0; j < 12; j++) begin
      if (s_txd[10*BP*j] !== 1'b0) ferr++;
      if (s_txd[10*BP*j + 9*BP] !== 1'b1) ferr++;
      for (int n = 0; n < 8; n++) b[n] = s_txd[10*BP*j + BP*(n+1)];
      check($sformatf("%s byte%0d", tag, j), {24'd0, b}, {24'd0, exp[95-8*j -: 8]});
    end
    for (int k = 0; k < NS; k++) begin
      if (s_busy[k] === 1'b1) nbusy++;
      if (s_done[k] !== 1'b0) ndone++;
    end
    check({tag, " framing/timing errors"}, 32'(ferr), 32'd0);
    check({tag, " busy cycles"}, 32'(nbusy), 32'(NS));
    check({tag, " early done"}, 32'(ndone), 32'd0);
    check({tag, " done at end"}, 32'(s_done[NS]), 32'd1);
    check({tag, " busy at end"}, 32'(s_busy[NS]), 32'd0);
    check({tag, " txd at end"}, 32'(s_txd[NS]), 32'd1);
  endtask

  task automatic check_idle(input string tag, input int cycles);
    int viol;
    viol = 0;
    for (int i = 0; i < cycles; i++) begin
      if (txd !== 1'b1 || busy !== 1'b0 || done !== 1'b0) viol++;
      @(negedge clk);
    end
    check(tag, 32'(viol), 32'd0);
  endtask

  initial begin
    logic [7:0] rx [12];
    logic [95:0] exp_s;
    int ferr, tmo, ndone;

    vecs[0] = '{"deadbeef", 8'h01, 32'h8000_0000, 32'hDEAD_BEEF, 96'h5AA5_01_80000000_DEADBEEF_A3};
    vecs[1] = '{"mixed",    8'h12, 32'h3456_7890, 32'hABCD_EF01, 96'h5AA5_12_34567890_ABCDEF01_10};
    vecs[2] = '{"zeros",    8'h00, 32'h0000_0000, 32'h0000_0000, 96'h5AA5_00_00000000_00000000_00};

    reset = 1'b1; start = 1'b0; cmd = '0; addr = '0; data = '0;
    start_s = 1'b0; cmd_s = '0; addr_s = '0; data_s = '0;
    repeat (3) @(negedge clk);
    check("reset txd",  32'(txd),  32'd1);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 3; v++) begin
      send(vecs[v].name, vecs[v].cmd, vecs[v].addr, vecs[v].data);
      capture(-1, 8'h00, 32'h0, 32'h0);
      check_frame(vecs[v].name, vecs[v].exp);
    end

    // Start mid-frame with different fields must be ignored entirely.
    send("ignored", 8'h01, 32'h8000_0000, 32'hDEAD_BEEF);
    capture(100, 8'hFF, 32'h1111_2222, 32'h3333_4444);
    check_frame("ignored", vecs[0].exp);
    check_idle("no queued frame", 20);

    // Start in the done cycle: second frame follows with no gap.
    send("b2b", 8'h01, 32'h8000_0000, 32'hDEAD_BEEF);
    capture(NS, 8'h00, 32'h0, 32'h0);
    check_frame("b2b first", vecs[0].exp);
    capture(-1, 8'h00, 32'h0, 32'h0);
    check_frame("b2b second", vecs[2].exp);

    // Reset in byte 6 (addr[7:0]=00), data bit 3, which is driving a 0.
    send("abort", 8'hFF, 32'h0, 32'h0);
    repeat (10*BP*6 + BP*4 + 1) @(negedge clk);
    check("pre-reset txd", 32'(txd), 32'd0);
    reset = 1'b1;
    #1;
    check("async reset txd",  32'(txd),  32'd1);
    check("async reset busy", 32'(busy), 32'd0);
    ndone = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done !== 1'b0) ndone++;
    end
    reset = 1'b0;
    check("no done on abort", 32'(ndone), 32'd0);
    check_idle("idle after reset", 2 * 120 * BP);
    send("post-reset", 8'hFF, 32'h0, 32'h0);
    capture(-1, 8'h00, 32'h0, 32'h0);
    check_frame("post-reset", 96'h5AA5_FF_00000000_00000000_FF);

    // Slower instance read by a mid-bit sampling receiver.
    exp_s = vecs[1].exp;
    ferr = 0; tmo = 0;
    start_s = 1'b1; cmd_s = vecs[1].cmd; addr_s = vecs[1].addr; data_s = vecs[1].data;
    @(negedge clk);
    start_s = 1'b0;
    for (int j = 0; j < 12; j++) begin
      int t;
      t = 0;
      while (txd_s !== 1'b0 && t < 4 * BP_SLOW) begin
        @(negedge clk);
        t++;
      end
      if (t >= 4 * BP_SLOW) tmo++;
      repeat (BP_SLOW / 2) @(negedge clk);
      if (txd_s !== 1'b0) ferr++;
      for (int n = 0; n < 8; n++) begin
        repeat (BP_SLOW) @(negedge clk);
        rx[j][n] = txd_s;
      end
      repeat (BP_SLOW) @(negedge clk);
      if (txd_s !== 1'b1) ferr++;
    end
    for (int j = 0; j < 12; j++)
      check($sformatf("slow byte%0d", j), {24'd0, rx[j]}, {24'd0, exp_s[95-8*j -: 8]});
    check("slow framing errors", 32'(ferr), 32'd0);
    check("slow timeouts", 32'(tmo), 32'd0);
    begin
      int t;
      t = 0;
      while (busy_s !== 1'b0 && t < BP_SLOW) begin
        @(negedge clk);
        t++;
      end
      check("slow busy falls", 32'(busy_s), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
